// File: rtl/pool_pkg.sv
// Shared types and constants for the 2x2 average-pooling stage.
package pool_pkg;

    typedef logic signed [15:0] pixel_t;
    typedef logic signed [17:0] acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int POOL_SHIFT = 2;

    function automatic acc_t sext_pixel(input pixel_t p);
        return acc_t'({{2{p[15]}}, p});
    endfunction

endpackage

// File: rtl/pool_window_counter.sv
// Window (i,j) and tap (k) counters; produces the registered read address
// for the next tap and the output address of the current window.
module pool_window_counter #(
    parameter int N   = 28,
    parameter int AW  = ((N * N) > 1) ? $clog2(N * N) : 1,
    parameter int OAW = (((N / 2) * (N / 2)) > 1) ? $clog2((N / 2) * (N / 2)) : 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           i_clear,
    input  logic           i_tap_adv,
    input  logic           i_win_adv,
    input  logic           i_rd_next,
    output logic [AW-1:0]  o_rd_addr,
    output logic [OAW-1:0] o_wr_addr,
    output logic           o_first_tap,
    output logic           o_last_tap,
    output logic           o_last_window
);

    localparam int M  = N / 2;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    logic [CW-1:0] r_i, r_j, w_i_nxt, w_j_nxt;
    logic [1:0]    r_k, w_k_nxt;
    logic [AW-1:0] r_rd_addr;
    int            w_rd_full;

    assign o_first_tap   = (r_k == 2'd0);
    assign o_last_tap    = (r_k == 2'd3);
    assign o_last_window = (int'(r_i) == M - 1) && (int'(r_j) == M - 1);
    assign o_wr_addr     = OAW'(int'(r_i) * M + int'(r_j));
    assign o_rd_addr     = r_rd_addr;

    // Next counter values; j advances fastest and everything wraps after the last window.
    always_comb begin
        w_i_nxt = r_i;
        w_j_nxt = r_j;
        w_k_nxt = r_k;
        if (i_clear) begin
            w_i_nxt = '0;
            w_j_nxt = '0;
            w_k_nxt = 2'd0;
        end else if (i_win_adv) begin
            w_k_nxt = 2'd0;
            if (o_last_window) begin
                w_i_nxt = '0;
                w_j_nxt = '0;
            end else if (int'(r_j) == M - 1) begin
                w_j_nxt = '0;
                w_i_nxt = r_i + CW'(1);
            end else begin
                w_j_nxt = r_j + CW'(1);
            end
        end else if (i_tap_adv) begin
            w_k_nxt = r_k + 2'd1;
        end else begin
            w_k_nxt = r_k;
        end
        // Row is 2i + k[1], column is 2j + k[0].
        w_rd_full = int'({w_i_nxt, w_k_nxt[1]}) * N + int'({w_j_nxt, w_k_nxt[0]});
    end

    // Counter and read-address registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_i       <= '0;
            r_j       <= '0;
            r_k       <= 2'd0;
            r_rd_addr <= '0;
        end else begin
            r_i       <= w_i_nxt;
            r_j       <= w_j_nxt;
            r_k       <= w_k_nxt;
            r_rd_addr <= i_rd_next ? AW'(w_rd_full) : '0;
        end
    end

endmodule

// File: rtl/pool2x2_scheduler.sv
// 2x2 stride-2 average-pooling sequencer: fetches four pixels per window,
// writes their floored mean, and signals completion with start/finish.
module pool2x2_scheduler #(
    parameter int N   = 28,
    parameter int AW  = ((N * N) > 1) ? $clog2(N * N) : 1,
    parameter int OAW = (((N / 2) * (N / 2)) > 1) ? $clog2((N / 2) * (N / 2)) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  finish,
    output logic                  busy,
    output logic                  rd_en,
    output logic [AW-1:0]         rd_addr,
    input  logic signed [15:0]    rd_data,
    output logic                  wr_en,
    output logic [OAW-1:0]        wr_addr,
    output logic signed [15:0]    wr_data
);

    import pool_pkg::*;

    localparam int M = N / 2;

    state_t         r_state, w_state_nxt;
    acc_t           r_acc, w_sum, w_avg;
    logic           r_rd_en;
    logic           w_first_tap, w_last_tap, w_last_window;
    logic [OAW-1:0] w_wr_addr;

    pool_window_counter #(.N(N), .AW(AW), .OAW(OAW)) u_counter (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_clear       (r_state == IDLE),
        .i_tap_adv     (r_state == FETCH),
        .i_win_adv     (r_state == WRITE),
        .i_rd_next     (w_state_nxt == FETCH),
        .o_rd_addr     (rd_addr),
        .o_wr_addr     (w_wr_addr),
        .o_first_tap   (w_first_tap),
        .o_last_tap    (w_last_tap),
        .o_last_window (w_last_window)
    );

    assign w_sum = r_acc + sext_pixel(rd_data);
    assign w_avg = w_sum >>> POOL_SHIFT;
    assign rd_en = r_rd_en;

    // Next-state logic; a held start cannot retrigger from DONE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = start ? ((M == 0) ? DONE : FETCH) : IDLE;
            FETCH:   w_state_nxt = w_last_tap ? WRITE : FETCH;
            WRITE:   w_state_nxt = w_last_window ? DONE : FETCH;
            DONE:    w_state_nxt = start ? DONE : IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Status and write-port outputs decoded from the state register.
    always_comb begin
        busy    = (r_state == FETCH) || (r_state == WRITE);
        finish  = (r_state == DONE);
        wr_en   = (r_state == WRITE);
        wr_addr = wr_en ? w_wr_addr : '0;
        wr_data = wr_en ? pixel_t'(w_avg[15:0]) : 16'sd0;
    end

    // State, read strobe and accumulator; tap 0 has no returned data yet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_rd_en <= 1'b0;
            r_acc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rd_en <= (w_state_nxt == FETCH);
            r_acc   <= ((r_state == FETCH) && !w_first_tap) ? w_sum : '0;
        end
    end

endmodule
